// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the CPU and a DMA channel.
// DMA wins ties, but only DMA_MAX_BURST times in a row while the CPU waits.
module mem_arbiter #(
   parameter int AW            = 12,
   parameter int DW            = 12,
   parameter int MEM_LAT       = 1,
   parameter int DMA_MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic          busy
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int BC_W  = $clog2(DMA_MAX_BURST + 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
   localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(DMA_MAX_BURST);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic             cpu_ack_q, cpu_ack_d;
   logic             dma_ack_q, dma_ack_d;
   logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0]    dma_rdata_q, dma_rdata_d;
   logic             busy_q, busy_d;

   logic             grant_dma, grant_cpu, win_we;
   logic [AW-1:0]    win_addr;
   logic [DW-1:0]    win_wdata;

   // Tie-break: DMA loses only once it has used up its burst allowance.
   always_comb begin
      grant_dma = dma_req && (!cpu_req || (burst_cnt_q != BURST_MAX));
      grant_cpu = cpu_req && !grant_dma;
      win_we    = grant_dma ? dma_we    : cpu_we;
      win_addr  = grant_dma ? dma_addr  : cpu_addr;
      win_wdata = grant_dma ? dma_wdata : cpu_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (grant_dma || grant_cpu) state_d = win_we ? S_WR : S_RD;
         end
         S_RD: begin
            if (lat_cnt_q == LAT_LAST) state_d = S_ACK;
         end
         S_WR:    state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      owner_d     = owner_q;
      lat_cnt_d   = lat_cnt_q;
      burst_cnt_d = burst_cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      busy_d      = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            // Any idle cycle without a waiting CPU resets the DMA allowance.
            if (!cpu_req)
               burst_cnt_d = '0;
            else if (grant_dma)
               burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + BC_W'(1);
            else
               burst_cnt_d = '0;
            if (grant_dma || grant_cpu) begin
               owner_d     = grant_dma;
               mem_addr_d  = win_addr;
               mem_wdata_d = win_wdata;
               lat_cnt_d   = '0;
               mem_read_d  = !win_we;
               mem_write_d = win_we;
            end
         end
         S_RD: begin
            if (lat_cnt_q == LAT_LAST) begin
               if (owner_q) begin
                  dma_rdata_d = mem_rdata;
                  dma_ack_d   = 1'b1;
               end else begin
                  cpu_rdata_d = mem_rdata;
                  cpu_ack_d   = 1'b1;
               end
            end else begin
               lat_cnt_d  = lat_cnt_q + LAT_W'(1);
               mem_read_d = 1'b1;
            end
         end
         S_WR: begin
            dma_ack_d = owner_q;
            cpu_ack_d = !owner_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q     <= 1'b1;
         lat_cnt_q   <= '0;
         burst_cnt_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         lat_cnt_q   <= lat_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign owner     = owner_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus arbitration, starvation, reset and latency sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   logic        cpu_req, cpu_we, cpu_ack, dma_req, dma_we, dma_ack;
   logic [11:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
   logic [11:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, owner, busy;

   logic        t3_cpu_req, t3_cpu_we, t3_cpu_ack, t3_dma_req, t3_dma_we, t3_dma_ack;
   logic [11:0] t3_cpu_addr, t3_cpu_wdata, t3_cpu_rdata, t3_dma_addr, t3_dma_wdata, t3_dma_rdata;
   logic [11:0] t3_mem_addr, t3_mem_wdata, t3_mem_rdata;
   logic        t3_mem_read, t3_mem_write, t3_owner, t3_busy;

   mem_arbiter #(.AW(12), .DW(12), .MEM_LAT(1), .DMA_MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
   );

   mem_arbiter #(.AW(12), .DW(12), .MEM_LAT(3), .DMA_MAX_BURST(4)) dut3 (
      .clk(clk), .rst(rst),
      .cpu_req(t3_cpu_req), .cpu_we(t3_cpu_we), .cpu_addr(t3_cpu_addr), .cpu_wdata(t3_cpu_wdata),
      .cpu_ack(t3_cpu_ack), .cpu_rdata(t3_cpu_rdata),
      .dma_req(t3_dma_req), .dma_we(t3_dma_we), .dma_addr(t3_dma_addr), .dma_wdata(t3_dma_wdata),
      .dma_ack(t3_dma_ack), .dma_rdata(t3_dma_rdata),
      .mem_addr(t3_mem_addr), .mem_wdata(t3_mem_wdata), .mem_read(t3_mem_read),
      .mem_write(t3_mem_write), .mem_rdata(t3_mem_rdata), .owner(t3_owner), .busy(t3_busy)
   );

   // Memory model: data is only valid in the last cycle of the read strobe.
   logic [11:0] mem [0:4095];
   int          rd_cnt = 0;
   int          rd3_cnt = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rd_cnt  <= (mem_read && !rst) ? rd_cnt + 1 : 0;
      rd3_cnt <= (t3_mem_read && !rst) ? rd3_cnt + 1 : 0;
      if (rst) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 12'h000;
         mem[12'h123] <= 12'h5A5;
         mem[12'h456] <= 12'h777;
      end else if (mem_write) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign mem_rdata    = (mem_read && rd_cnt == 0) ? mem[mem_addr] : 12'hBAD;
   assign t3_mem_rdata = (t3_mem_read && rd3_cnt == 2) ? mem[t3_mem_addr] : 12'hBAD;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      bit          we;
      logic [11:0] rdata;
   } exp_t;

   exp_t        cpu_q[$];
   exp_t        dma_q[$];
   exp_t        mc, md;
   logic [11:0] last_cpu_rd, last_dma_rd;

   always @(negedge clk) begin
      if (!rst) check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      if (cpu_ack) begin
         if (cpu_q.size() == 0) check("cpu_ack_spurious", 32'd1, 32'd0);
         else begin
            mc = cpu_q.pop_front();
            check("cpu_ack_owner", 32'(owner), 32'd0);
            if (!mc.we) check("cpu_ack_rdata", 32'(cpu_rdata), 32'(mc.rdata));
         end
      end
      if (dma_ack) begin
         if (dma_q.size() == 0) check("dma_ack_spurious", 32'd1, 32'd0);
         else begin
            md = dma_q.pop_front();
            check("dma_ack_owner", 32'(owner), 32'd1);
            if (!md.we) check("dma_ack_rdata", 32'(dma_rdata), 32'(md.rdata));
         end
      end
   end

   task automatic do_txn(input bit is_dma, input bit we, input logic [11:0] addr,
                         input logic [11:0] wdata, input logic [11:0] exp_rd,
                         input int exp_lat, input string tag);
      int   t0, rdn, wrn, lat;
      bit   seen;
      exp_t e;
      @(posedge clk); #1;
      t0 = cyc;
      e.we = we;
      e.rdata = exp_rd;
      if (is_dma) begin
         dma_q.push_back(e);
         dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
      end else begin
         cpu_q.push_back(e);
         cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end
      rdn = 0; wrn = 0; lat = -1; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (mem_read) begin
            rdn++;
            check({tag, "_rd_addr"}, 32'(mem_addr), 32'(addr));
         end
         if (mem_write) begin
            wrn++;
            check({tag, "_wr_addr"}, 32'(mem_addr), 32'(addr));
            check({tag, "_wr_data"}, 32'(mem_wdata), 32'(wdata));
         end
         if (is_dma ? dma_ack : cpu_ack) begin
            seen = 1'b1;
            lat = cyc - t0;
            cpu_req = 1'b0;
            dma_req = 1'b0;
         end
      end
      check({tag, "_ack_seen"}, 32'(seen), 32'd1);
      check({tag, "_ack_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_rd_cycles"}, 32'(rdn), we ? 32'd0 : 32'd1);
      check({tag, "_wr_cycles"}, 32'(wrn), we ? 32'd1 : 32'd0);
      if (!is_dma && !we) last_cpu_rd = exp_rd;
      if (is_dma && !we)  last_dma_rd = exp_rd;
      check({tag, "_cpu_rdata_hold"}, 32'(cpu_rdata), 32'(last_cpu_rd));
      check({tag, "_dma_rdata_hold"}, 32'(dma_rdata), 32'(last_dma_rd));
   endtask

   typedef struct {
      bit          is_dma;
      bit          we;
      logic [11:0] addr;
      logic [11:0] wdata;
      logic [11:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t       vecs[9];
   int         t0, wr_c, rd_c, dack_c, cack_c, ndma, ncpu, burst_at_cpu, rdn;
   int         order[$];
   logic [6:0] pat;
   exp_t       e0;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 12'h123, 12'h000, 12'h5A5, 2};
      vecs[1] = '{1'b1, 1'b1, 12'h7FF, 12'h0F0, 12'h000, 2};
      vecs[2] = '{1'b1, 1'b0, 12'h7FF, 12'h000, 12'h0F0, 2};
      vecs[3] = '{1'b0, 1'b1, 12'h000, 12'hFFF, 12'h000, 2};
      vecs[4] = '{1'b0, 1'b0, 12'h000, 12'h000, 12'hFFF, 2};
      vecs[5] = '{1'b1, 1'b0, 12'h123, 12'h000, 12'h5A5, 2};
      vecs[6] = '{1'b0, 1'b1, 12'hABC, 12'h321, 12'h000, 2};
      vecs[7] = '{1'b1, 1'b0, 12'hABC, 12'h000, 12'h321, 2};
      vecs[8] = '{1'b0, 1'b0, 12'h456, 12'h000, 12'h777, 2};

      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      t3_cpu_req = 1'b0; t3_cpu_we = 1'b0; t3_cpu_addr = '0; t3_cpu_wdata = '0;
      t3_dma_req = 1'b0; t3_dma_we = 1'b0; t3_dma_addr = '0; t3_dma_wdata = '0;
      last_cpu_rd = '0; last_dma_rd = '0;

      // Reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      check("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
      check("rst_owner_busy", 32'({owner, busy}), 32'b10);
      check("rst3_outs", 32'({t3_mem_read, t3_mem_write, t3_cpu_ack, t3_dma_ack, t3_owner, t3_busy}), 32'b000010);
      check("rst3_data", 32'({t3_mem_addr, t3_mem_wdata}), 32'd0);
      check("rst3_rdata", 32'({t3_cpu_rdata, t3_dma_rdata}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         do_txn(vecs[i].is_dma, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_lat, $sformatf("v%0d", i));

      // Both request together: DMA write first, CPU read right after.
      @(posedge clk); #1;
      t0 = cyc;
      e0.we = 1'b0; e0.rdata = 12'h5A5; cpu_q.push_back(e0);
      e0.we = 1'b1; e0.rdata = 12'h000; dma_q.push_back(e0);
      cpu_we = 1'b0; cpu_addr = 12'h123; cpu_req = 1'b1;
      dma_we = 1'b1; dma_addr = 12'h200; dma_wdata = 12'h111; dma_req = 1'b1;
      wr_c = -1; rd_c = -1; dack_c = -1; cack_c = -1; ndma = 0; ncpu = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (mem_write && wr_c < 0) begin
            wr_c = cyc - t0;
            check("sim_wr_addr", 32'(mem_addr), 32'h200);
         end
         if (mem_read && rd_c < 0) rd_c = cyc - t0;
         if (dma_ack) begin ndma++; dack_c = cyc - t0; dma_req = 1'b0; end
         if (cpu_ack) begin ncpu++; cack_c = cyc - t0; cpu_req = 1'b0; end
      end
      check("sim_wr_cycle", 32'(wr_c), 32'd1);
      check("sim_dma_ack_cycle", 32'(dack_c), 32'd2);
      check("sim_rd_cycle", 32'(rd_c), 32'd4);
      check("sim_cpu_ack_cycle", 32'(cack_c), 32'd5);
      check("sim_ack_counts", 32'({ndma[3:0], ncpu[3:0]}), 32'h11);

      // DMA writes held continuously against a waiting CPU read.
      @(posedge clk); #1;
      t0 = cyc;
      e0.we = 1'b0; e0.rdata = 12'h5A5; cpu_q.push_back(e0);
      e0.we = 1'b1; e0.rdata = 12'h000;
      for (int i = 0; i < 6; i++) dma_q.push_back(e0);
      cpu_we = 1'b0; cpu_addr = 12'h123; cpu_req = 1'b1;
      dma_we = 1'b1; dma_addr = 12'h300; dma_wdata = 12'h0AA; dma_req = 1'b1;
      order.delete();
      ndma = 0; cack_c = -1; burst_at_cpu = -1;
      for (int k = 0; k < 40 && ndma < 6; k++) begin
         @(negedge clk);
         if (mem_read && !owner && burst_at_cpu < 0) burst_at_cpu = 32'(dut.burst_cnt_q);
         if (dma_ack) begin
            order.push_back(1); ndma++;
            if (ndma == 6) dma_req = 1'b0;
         end
         if (cpu_ack) begin
            order.push_back(0); cack_c = cyc - t0; cpu_req = 1'b0;
         end
      end
      pat = 7'b1101111;
      check("burst_ack_count", 32'(order.size()), 32'd7);
      for (int i = 0; i < order.size() && i < 7; i++)
         check($sformatf("burst_order%0d", i), 32'(order[i]), 32'(pat[i]));
      check("burst_cpu_ack_cycle", 32'(cack_c), 32'd14);
      check("burst_cnt_after_cpu", 32'(burst_at_cpu), 32'd0);
      @(posedge clk);
      check("burst_queues_drained", 32'(cpu_q.size() + dma_q.size()), 32'd0);

      // Reset in the first read cycle aborts the transaction.
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_addr = 12'h456; cpu_req = 1'b1;
      @(posedge clk); #2;
      check("abort_rd_active", 32'(mem_read), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_rd_drop", 32'(mem_read), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'({busy, mem_read, mem_write, cpu_ack}), 32'd0);
      check("abort_state", 32'(dut.state_q), 32'd0);
      check("abort_rdata_rst", 32'(cpu_rdata), 32'd0);
      last_cpu_rd = '0; last_dma_rd = '0;
      do_txn(1'b0, 1'b0, 12'h456, 12'h000, 12'h777, 2, "reissue");

      // Three-cycle memory latency on the second instance.
      @(posedge clk); #1;
      t0 = cyc;
      t3_cpu_we = 1'b0; t3_cpu_addr = 12'h123; t3_cpu_req = 1'b1;
      rdn = 0; rd_c = -1; cack_c = -1;
      for (int k = 0; k < 15 && cack_c < 0; k++) begin
         @(negedge clk);
         if (t3_mem_read) begin
            rdn++;
            if (rd_c < 0) rd_c = cyc - t0;
            check("lat3_addr_stable", 32'(t3_mem_addr), 32'h123);
         end
         if (t3_cpu_ack) begin
            cack_c = cyc - t0;
            check("lat3_rdata", 32'(t3_cpu_rdata), 32'h5A5);
            check("lat3_owner", 32'({t3_owner, t3_dma_ack}), 32'd0);
            t3_cpu_req = 1'b0;
         end
      end
      check("lat3_rd_cycles", 32'(rdn), 32'd3);
      check("lat3_first_rd", 32'(rd_c), 32'd1);
      check("lat3_ack_cycle", 32'(cack_c), 32'd4);

      repeat (2) @(negedge clk);
      check("final_idle", 32'({busy, t3_busy}), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
